// File: rtl/wash_water_arbiter_if.sv
// Valve-arbiter bundle: per-machine request/done in, one-hot grant, valve drive,
// busy index and sticky timeout flags out.
interface wash_water_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]         req;
  logic [N-1:0]         done;
  logic [N-1:0]         grant;
  logic                 valve;
  logic [$clog2(N)-1:0] busy_id;
  logic [N-1:0]         timeout;

  modport master (output req, output done,
                  input grant, input valve, input busy_id, input timeout);
  modport slave  (input req, input done,
                  output grant, output valve, output busy_id, output timeout);
endinterface

// File: rtl/wash_water_arbiter.sv
// Round-robin hot-water valve arbiter with post-release settle interval.
// Optional hold watchdog and sticky timeout flags: define WASH_ARB_WATCHDOG_EN.
module wash_water_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int SETTLE   = 2
) (
  input  logic                 timer,
  input  logic                 reset,
  wash_water_arbiter_if.slave  bus,
  output logic [1:0]           o_dbg_state
);
  localparam int LW = $clog2(N);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int HW = $clog2(MAX_HOLD) + 1;

  if (N < 2 || N > 8 || MAX_HOLD < 2 || SETTLE < 1) begin : g_bad_param
    $error("wash_water_arbiter: parameter out of range");
  end

  // Handshake: a machine holds req high while it needs water; it owns the valve
  // from the cycle grant is seen high until it drops req or pulses done.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_SETTLE = 2'd2} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_grant, w_grant_nxt;
  logic          r_valve;
  logic [LW-1:0] r_busy_id, w_busy_nxt;
  logic [LW-1:0] r_last, w_last_nxt;
  logic [SW-1:0] r_settle_cnt, w_settle_nxt;
  logic [LW-1:0] w_sel;
  logic          w_found;
`ifdef WASH_ARB_WATCHDOG_EN
  logic [HW-1:0] r_hold_cnt, w_hold_nxt;
  logic [N-1:0]  r_timeout, w_timeout_nxt;
`endif

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!w_found && bus.req[(int'(r_last) + i) % N]) begin
        w_found = 1'b1;
        w_sel   = LW'((int'(r_last) + i) % N);
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_busy_nxt    = r_busy_id;
    w_last_nxt    = r_last;
    w_settle_nxt  = r_settle_cnt;
`ifdef WASH_ARB_WATCHDOG_EN
    w_hold_nxt    = r_hold_cnt;
    w_timeout_nxt = r_timeout;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_grant_nxt = N'(1) << w_sel;
          w_busy_nxt  = w_sel;
          w_last_nxt  = w_sel;
`ifdef WASH_ARB_WATCHDOG_EN
          w_hold_nxt  = '0;
`endif
        end
      end
      S_GRANT: begin
        // Normal release outranks the watchdog on the same edge.
        if (bus.done[r_busy_id] || !bus.req[r_busy_id]) begin
          w_state_nxt  = S_SETTLE;
          w_grant_nxt  = '0;
          w_settle_nxt = '0;
        end
`ifdef WASH_ARB_WATCHDOG_EN
        else if (r_hold_cnt == HW'(MAX_HOLD - 1)) begin
          w_state_nxt              = S_SETTLE;
          w_grant_nxt              = '0;
          w_settle_nxt             = '0;
          w_timeout_nxt[r_busy_id] = 1'b1;
        end else if (r_hold_cnt != '1) begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
`endif
      end
      S_SETTLE: begin
        if (r_settle_cnt == SW'(SETTLE - 1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_settle_nxt = r_settle_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge timer) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_valve      <= 1'b0;
      r_busy_id    <= '0;
      r_last       <= LW'(N - 1);
      r_settle_cnt <= '0;
`ifdef WASH_ARB_WATCHDOG_EN
      r_hold_cnt   <= '0;
      r_timeout    <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_valve      <= |w_grant_nxt;
      r_busy_id    <= w_busy_nxt;
      r_last       <= w_last_nxt;
      r_settle_cnt <= w_settle_nxt;
`ifdef WASH_ARB_WATCHDOG_EN
      r_hold_cnt   <= w_hold_nxt;
      r_timeout    <= w_timeout_nxt;
`endif
    end
  end

  assign bus.grant   = r_grant;
  assign bus.valve   = r_valve;
  assign bus.busy_id = r_busy_id;
`ifdef WASH_ARB_WATCHDOG_EN
  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = '0;
`endif
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_wash_water_arbiter.sv
// Directed bench for wash_water_arbiter (N=4, MAX_HOLD=8, SETTLE=2); watchdog
// scenarios follow WASH_ARB_WATCHDOG_EN.
module tb_wash_water_arbiter;
  logic       timer;
  logic       reset;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  wash_water_arbiter_if #(.N(4)) bus ();

  wash_water_arbiter #(.N(4), .MAX_HOLD(8), .SETTLE(2)) dut (
    .timer       (timer),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial timer = 1'b0;
  always #5 timer = ~timer;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge timer);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.done = '0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = 4'b1111;
    bus.done = 4'b1111;
    step(2);
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", bus.grant); end
    checks++; if (bus.valve !== 1'b0) begin errors++; $display("FAIL reset_valve got %b exp 0", bus.valve); end
    checks++; if (bus.busy_id !== 2'd0) begin errors++; $display("FAIL reset_busy got %0d exp 0", bus.busy_id); end
    checks++; if (bus.timeout !== 4'b0000) begin errors++; $display("FAIL reset_timeout got %b exp 0000", bus.timeout); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    reset = 1'b0;
    bus.req = '0;
    bus.done = '0;
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0001;
    step(1);
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", bus.grant); end
    checks++; if (bus.valve !== 1'b1) begin errors++; $display("FAIL single_valve got %b exp 1", bus.valve); end
    bus.done = 4'b0001;
    step(1);
    bus.done = 4'b0000;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL single_release got %b exp 0000", bus.grant); end
    checks++; if (bus.valve !== 1'b0) begin errors++; $display("FAIL single_valve_off got %b exp 0", bus.valve); end
    checks++; if (dbg_state !== ST_SETTLE) begin errors++; $display("FAIL single_settle_state got %0d exp 2", dbg_state); end
    // req stays high: the regrant may appear only on the third edge after release
    step(1);
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL gap_edge1 got %b exp 0000", bus.grant); end
    step(1);
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL gap_edge2 got %b exp 0000", bus.grant); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL gap_idle_state got %0d exp 0", dbg_state); end
    step(1);
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL gap_edge3 got %b exp 0001", bus.grant); end
    bus.req = 4'b0000;
    step(4);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    bus.req = 4'b1111;
    step(1);
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      checks++; if (bus.grant !== exp_g) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", i, bus.grant, exp_g); end
      checks++; if (bus.busy_id !== 2'(i % 4)) begin errors++; $display("FAIL rr_busy%0d got %0d exp %0d", i, bus.busy_id, i % 4); end
      bus.done = 4'b1111;
      step(1);
      bus.done = 4'b0000;
      checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rr_release%0d got %b exp 0000", i, bus.grant); end
      checks++; if (bus.busy_id !== 2'(i % 4)) begin errors++; $display("FAIL rr_busy_hold%0d got %0d exp %0d", i, bus.busy_id, i % 4); end
      step(3);
    end
    bus.req = 4'b0000;
    step(4);
  endtask

  task automatic test_wrap_and_ignore();
    do_reset();
    bus.req = 4'b0100;
    step(1);
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL wrap_first got %b exp 0100", bus.grant); end
    // done on a non-granted index must not release the valve
    bus.req = 4'b0101;
    bus.done = 4'b0001;
    step(1);
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL ignore_done got %b exp 0100", bus.grant); end
    bus.done = 4'b0100;
    step(1);
    bus.done = 4'b0000;
    step(3);
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL wrap_grant got %b exp 0001", bus.grant); end
    checks++; if (bus.busy_id !== 2'd0) begin errors++; $display("FAIL wrap_busy got %0d exp 0", bus.busy_id); end
    // dropping req of the granted machine releases it
    bus.req = 4'b0100;
    step(1);
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL req_drop got %b exp 0000", bus.grant); end
    checks++; if (dbg_state !== ST_SETTLE) begin errors++; $display("FAIL req_drop_state got %0d exp 2", dbg_state); end
    bus.req = 4'b0000;
    step(4);
  endtask

  task automatic test_watchdog();
    int high_cycles;
    bit dropped;
    do_reset();
    bus.req = 4'b0010;
    high_cycles = 0;
    dropped = 1'b0;
    for (int i = 0; i < 20 && !dropped; i++) begin
      step(1);
      if (bus.grant === 4'b0010) high_cycles++;
      else if (high_cycles > 0) dropped = 1'b1;
    end
`ifdef WASH_ARB_WATCHDOG_EN
    checks++; if (high_cycles !== 8) begin errors++; $display("FAIL wd_hold_cycles got %0d exp 8", high_cycles); end
    checks++; if (bus.timeout !== 4'b0010) begin errors++; $display("FAIL wd_timeout got %b exp 0010", bus.timeout); end
    bus.req = 4'b0001;
    step(3);
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL wd_next_grant got %b exp 0001", bus.grant); end
    checks++; if (bus.timeout !== 4'b0010) begin errors++; $display("FAIL wd_sticky got %b exp 0010", bus.timeout); end
`else
    checks++; if (high_cycles !== 20) begin errors++; $display("FAIL nowd_hold_cycles got %0d exp 20", high_cycles); end
    checks++; if (bus.timeout !== 4'b0000) begin errors++; $display("FAIL nowd_timeout got %b exp 0000", bus.timeout); end
`endif
    bus.req = 4'b0000;
    step(4);
  endtask

  task automatic test_done_on_expiry();
    do_reset();
    bus.req = 4'b0010;
    step(1);
    step(7);
    checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL expiry_pre got %b exp 0010", bus.grant); end
    bus.done = 4'b0010;
    step(1);
    bus.done = 4'b0000;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL expiry_release got %b exp 0000", bus.grant); end
    checks++; if (bus.timeout !== 4'b0000) begin errors++; $display("FAIL expiry_timeout got %b exp 0000", bus.timeout); end
    bus.req = 4'b0000;
    step(4);
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 4'b1000;
    step(3);
    checks++; if (bus.busy_id !== 2'd3) begin errors++; $display("FAIL mid_pre_busy got %0d exp 3", bus.busy_id); end
    reset = 1'b1;
    step(1);
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL mid_grant got %b exp 0000", bus.grant); end
    checks++; if (bus.valve !== 1'b0) begin errors++; $display("FAIL mid_valve got %b exp 0", bus.valve); end
    checks++; if (bus.busy_id !== 2'd0) begin errors++; $display("FAIL mid_busy got %0d exp 0", bus.busy_id); end
    checks++; if (bus.timeout !== 4'b0000) begin errors++; $display("FAIL mid_timeout got %b exp 0000", bus.timeout); end
    reset = 1'b0;
    bus.req = 4'b0000;
    step(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.req = '0;
    bus.done = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_and_ignore();
    test_watchdog();
    test_done_on_expiry();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
